uart_tx: RTL
============

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 8, clkTx cycles per serial bit; legal range 2..16.
REQ-002 clkTx  input  1  sole clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 txStart  input  1  request to send txData; sampled only in IDLE.
REQ-005 txData  input  8  byte to transmit; captured on the accepting edge.
REQ-006 serialOutput  output  1  UART line: idle high, LSB first.
REQ-007 txBusy  output  1  high while a frame is in progress.
REQ-008 txDone  output  1  one-cycle pulse when a frame completes.

Function
REQ-009 The block SHALL use a registered state machine with states IDLE, START, DATA, PARITY (only when PARITY_EN is defined) and STOP.
REQ-010 In IDLE, serialOutput SHALL be 1 and txBusy SHALL be 0.
REQ-011 In IDLE, txStart=1 at a rising edge SHALL capture txData into an internal shift register, enter START, drive serialOutput=0, set txBusy=1 and clear the bit counter, all on that same edge.
REQ-012 txStart SHALL be ignored outside IDLE; the captured byte SHALL be unaffected by later changes to txData.
REQ-013 Each bit (start, data, parity, stop) SHALL drive serialOutput for exactly CLKS_PER_BIT cycles, timed by a cycle counter that counts 0..CLKS_PER_BIT-1.
REQ-014 DATA SHALL send bit 0 first through bit 7 last, using a 3-bit bit index that wraps from 7 to exit DATA.
REQ-015 After bit 7, the block SHALL enter PARITY if PARITY_EN is defined and STOP otherwise.
REQ-016 STOP SHALL drive serialOutput=1 for CLKS_PER_BIT cycles, then return to IDLE on the edge that ends the stop bit.
REQ-017 On that same edge, txBusy SHALL go 0 and txDone SHALL go 1 for exactly one cycle.
REQ-018 Without parity, a frame SHALL occupy exactly 10*CLKS_PER_BIT cycles from the accepting edge to the txDone edge; with parity, 11*CLKS_PER_BIT.
REQ-019 txStart held high continuously SHALL produce back-to-back frames separated by exactly one IDLE cycle (serialOutput=1), since the next frame is accepted on the edge after txDone rises.
REQ-020 All outputs SHALL be driven directly from registers, with no combinational path from inputs to outputs.
REQ-021 Any illegal state encoding SHALL return to IDLE on the next edge, with serialOutput=1.

Reset
REQ-022 reset=1 at a rising edge SHALL force IDLE, serialOutput=1, txBusy=0, txDone=0, counters=0 and shift register=0, overriding txStart.
REQ-023 Reset asserted mid-frame SHALL abort the frame, driving the line high from the next edge, and SHALL NOT pulse txDone.
REQ-024 The first txStart SHALL be accepted on the first edge with reset=0.

Configuration
REQ-025 When PARITY_EN is defined, one PARITY bit SHALL follow bit 7, carrying even parity (the XOR of the 8 data bits), for CLKS_PER_BIT cycles.
REQ-026 When PARITY_EN is undefined, the PARITY state and its logic SHALL be absent and the frame SHALL be 8N1.

Verification
REQ-027 Basic frame: CLKS_PER_BIT=8, no parity, txData=8'hA5, one-cycle txStart -> line sequence 0,1,0,1,0,0,1,0,1,1, each bit held 8 cycles; txDone pulses exactly 80 cycles after the accepting edge.
REQ-028 Parity: PARITY_EN defined, txData=8'h07 -> parity bit 1 after the data bits, txDone at cycle 88; txData=8'h03 -> parity bit 0.
REQ-029 Busy masking: txStart pulsed with 8'h55 mid-frame of 8'hFF -> 8'h55 never sent; exactly one frame and one txDone observed.
REQ-030 Back-to-back: txStart held high with 8'h00 then 8'hFF -> two frames, one idle-high cycle between them, two txDone pulses 81 cycles apart.
REQ-031 Reset mid-frame: reset at cycle 30 of a frame -> serialOutput=1 and txBusy=0 on the next edge, no txDone; a new txStart with 8'h3C then produces a correct full frame.
REQ-032 Timing corner: CLKS_PER_BIT=2, txData=8'h81 -> frame of 20 cycles with each bit held exactly 2 cycles.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: 8-bit UART transmitter, start bit, LSB-first data, one stop bit.
// Define PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 8
) (
    input  logic       clkTx,
    input  logic       reset,
    input  logic       txStart,
    input  logic [7:0] txData,
    output logic       serialOutput,
    output logic       txBusy,
    output logic       txDone
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
`ifdef PARITY_EN
        StParity = 3'd3,
`endif
        StStop   = 3'd4
    } txStateT;

    // Four bits covers the whole legal CLKS_PER_BIT range of 2..16.
    localparam logic [3:0] LastCnt = 4'(CLKS_PER_BIT - 1);

    txStateT    stateQ, stateD;
    logic [3:0] cycleCntQ, cycleCntD;
    logic [2:0] bitIdxQ, bitIdxD;
    logic [7:0] shiftQ, shiftD;
    logic       serialQ, serialD;
    logic       busyQ, busyD;
    logic       doneQ, doneD;
    logic       bitEnd;
`ifdef PARITY_EN
    logic       parityQ, parityD;
`endif

    assign bitEnd       = (cycleCntQ == LastCnt);
    assign serialOutput = serialQ;
    assign txBusy       = busyQ;
    assign txDone       = doneQ;

    always_comb begin
        stateD    = stateQ;
        cycleCntD = cycleCntQ;
        bitIdxD   = bitIdxQ;
        shiftD    = shiftQ;
        serialD   = serialQ;
        busyD     = busyQ;
        doneD     = 1'b0;
`ifdef PARITY_EN
        parityD   = parityQ;
`endif
        case (stateQ)
            StIdle: begin
                serialD   = 1'b1;
                busyD     = 1'b0;
                cycleCntD = 4'd0;
                bitIdxD   = 3'd0;
                if (txStart) begin
                    stateD  = StStart;
                    shiftD  = txData;
                    serialD = 1'b0;
                    busyD   = 1'b1;
`ifdef PARITY_EN
                    parityD = ^txData;
`endif
                end
            end
            StStart: begin
                if (bitEnd) begin
                    stateD    = StData;
                    cycleCntD = 4'd0;
                    bitIdxD   = 3'd0;
                    serialD   = shiftQ[0];
                end else begin
                    cycleCntD = cycleCntQ + 4'd1;
                end
            end
            StData: begin
                if (bitEnd) begin
                    cycleCntD = 4'd0;
                    bitIdxD   = bitIdxQ + 3'd1;
                    if (bitIdxQ == 3'd7) begin
`ifdef PARITY_EN
                        stateD  = StParity;
                        serialD = parityQ;
`else
                        stateD  = StStop;
                        serialD = 1'b1;
`endif
                    end else begin
                        // Next data bit sits one place up before the shift lands.
                        shiftD  = shiftQ >> 1;
                        serialD = shiftQ[1];
                    end
                end else begin
                    cycleCntD = cycleCntQ + 4'd1;
                end
            end
`ifdef PARITY_EN
            StParity: begin
                if (bitEnd) begin
                    stateD    = StStop;
                    cycleCntD = 4'd0;
                    serialD   = 1'b1;
                end else begin
                    cycleCntD = cycleCntQ + 4'd1;
                end
            end
`endif
            StStop: begin
                serialD = 1'b1;
                if (bitEnd) begin
                    stateD    = StIdle;
                    cycleCntD = 4'd0;
                    busyD     = 1'b0;
                    doneD     = 1'b1;
                end else begin
                    cycleCntD = cycleCntQ + 4'd1;
                end
            end
            default: begin
                stateD    = StIdle;
                cycleCntD = 4'd0;
                bitIdxD   = 3'd0;
                serialD   = 1'b1;
                busyD     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clkTx) begin
        if (reset) begin
            stateQ    <= StIdle;
            cycleCntQ <= 4'd0;
            bitIdxQ   <= 3'd0;
            shiftQ    <= 8'd0;
            serialQ   <= 1'b1;
            busyQ     <= 1'b0;
            doneQ     <= 1'b0;
`ifdef PARITY_EN
            parityQ   <= 1'b0;
`endif
        end else begin
            stateQ    <= stateD;
            cycleCntQ <= cycleCntD;
            bitIdxQ   <= bitIdxD;
            shiftQ    <= shiftD;
            serialQ   <= serialD;
            busyQ     <= busyD;
            doneQ     <= doneD;
`ifdef PARITY_EN
            parityQ   <= parityD;
`endif
        end
    end

endmodule
